// File: rtl/spi_burst_pkg.sv
// Shared types and sizing helpers for the SPI burst sequencer.
package spi_burst_pkg;

    localparam int unsigned BYTE_W = 8;
    // Burst length counter: holds 1..256
    localparam int unsigned REM_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_ARM,
        ST_XFER,
        ST_HOLD
    } state_e;

    // Bits needed to count 0..max_val-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

    // Largest of two cycle counts, used to size the shared wait counter
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full are dropped.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer advance
    always_comb begin
        wr_d = do_push ? wr_q + PW'(1) : wr_q;
        rd_d = do_pop  ? rd_q + PW'(1) : rd_q;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte burst sequencer in front of a single-byte SPI master.
module spi_burst_ctrl
    import spi_burst_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] len,
    input  logic              abort,
    output logic              active,
    output logic              done,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [BYTE_W-1:0] spi_data_in,
    output logic              spi_ready_send,
    input  logic              spi_busy,
    input  logic [BYTE_W-1:0] spi_data_out,
    output logic              cs_n
);

    localparam int unsigned WAIT_W = cnt_width(max2(SETUP_CYCLES, HOLD_CYCLES));

    state_e            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              abort_q, abort_d;
    logic              cs_n_q, cs_n_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              rs_q, rs_d;
    logic [BYTE_W-1:0] sdi_q, sdi_d;

    logic              tx_full_c, tx_empty_c, tx_pop_c;
    logic [BYTE_W-1:0] tx_head_c;
    logic              rx_full_c, rx_empty_c, rx_push_c;
    logic              abort_seen_c, issue_c;

    assign tx_ready       = ~tx_full_c;
    assign rx_valid       = ~rx_empty_c;
    assign active         = active_q;
    assign done           = done_q;
    assign cs_n           = cs_n_q;
    assign spi_ready_send = rs_q;
    assign spi_data_in    = sdi_q;
    assign abort_seen_c   = abort_q | abort;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop_c),
        .full      (tx_full_c),
        .empty     (tx_empty_c),
        .head      (tx_head_c)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push_c),
        .push_data (spi_data_out),
        .pop       (rx_ready),
        .full      (rx_full_c),
        .empty     (rx_empty_c),
        .head      (rx_data)
    );

    // Next-state, counters, abort latch and registered output values
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        abort_d   = abort_seen_c;
        sdi_d     = sdi_q;
        rs_d      = 1'b0;
        done_d    = 1'b0;
        tx_pop_c  = 1'b0;
        rx_push_c = 1'b0;
        issue_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    rem_d   = (len == '0) ? REM_W'(256) : REM_W'(len);
                    wait_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort_seen_c) begin
                    wait_d  = '0;
                    state_d = ST_HOLD;
                end else if (wait_q == WAIT_W'(SETUP_CYCLES - 1)) begin
                    // Last setup cycle already evaluates the issue condition
                    issue_c = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (abort_seen_c) begin
                    wait_d  = '0;
                    state_d = ST_HOLD;
                end else begin
                    issue_c = 1'b1;
                end
            end
            ST_ARM: begin
                if (spi_busy) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!spi_busy) begin
                    rx_push_c = 1'b1;
                    rem_d     = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1) || abort_seen_c) begin
                        wait_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                if (wait_q == WAIT_W'(HOLD_CYCLES - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Byte issue: needs a TX byte and guaranteed room for its RX byte
        if (issue_c) begin
            state_d = ST_ISSUE;
            if (!tx_empty_c && !rx_full_c) begin
                tx_pop_c = 1'b1;
                sdi_d    = tx_head_c;
                rs_d     = 1'b1;
                state_d  = ST_ARM;
            end
        end

        cs_n_d   = (state_d == ST_IDLE);
        active_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            wait_q   <= '0;
            abort_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            rs_q     <= 1'b0;
            sdi_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wait_q   <= wait_d;
            abort_q  <= abort_d;
            cs_n_q   <= cs_n_d;
            active_q <= active_d;
            done_q   <= done_d;
            rs_q     <= rs_d;
            sdi_q    <= sdi_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a behavioural SPI master model.
module tb_spi_burst_ctrl;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned SETUP    = 2;
    localparam int unsigned HOLD     = 2;
    localparam int unsigned BUSY_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       active, done;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] spi_data_in;
    logic       spi_ready_send;
    logic       spi_busy;
    logic [7:0] spi_data_out;
    logic       cs_n;

    spi_burst_ctrl #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .len            (len),
        .abort          (abort),
        .active         (active),
        .done           (done),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .spi_data_in    (spi_data_in),
        .spi_ready_send (spi_ready_send),
        .spi_busy       (spi_busy),
        .spi_data_out   (spi_data_out),
        .cs_n           (cs_n)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: bytes the host has handed over, bytes the master returned
    logic [7:0] host_q[$];
    logic [7:0] tx_model[$];
    logic [7:0] rx_exp[$];

    int n_vec = 0;
    int n_err = 0;
    int rs_pulses = 0;
    int rx_pops = 0;
    int done_cnt = 0;
    int first_rs_cyc = -1;
    int last_push_cyc = 0;
    int done_cyc = 0;
    int cs_fall_cyc = 0;
    int rx_credit = 0;
    bit rx_en = 1'b1;
    bit flush = 1'b0;
    bit loopback = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, expected one (cyc %0d)", name, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Host writer: streams host_q into the TX port
    initial begin : writer
        bit hs;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            if (flush) begin
                host_q.delete();
                tx_valid = 1'b0;
            end else begin
                if (hs && rst_n) begin
                    tx_model.push_back(tx_data);
                    void'(host_q.pop_front());
                end
                tx_valid = (host_q.size() != 0);
                tx_data  = tx_valid ? host_q[0] : 8'h00;
            end
        end
    end

    // RX monitor: compares every popped byte against the scoreboard
    initial begin : reader
        bit hs;
        rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            hs = rx_valid && rx_ready && rst_n;
            if (hs) begin
                rx_pops++;
                if (rx_exp.size() == 0) fail("rx_unexpected_byte");
                else check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
            end
            @(posedge clk);
            #1;
            if (hs && rx_credit > 0) rx_credit--;
            rx_ready = rx_en ? ($urandom_range(3) != 0) : (rx_credit > 0);
        end
    end

    // SPI master model: busy for BUSY_LEN cycles starting one cycle after ready_send
    initial begin : master
        bit         req;
        bit         prev_rs;
        int         cnt;
        logic [7:0] last_sent;
        prev_rs      = 1'b0;
        cnt          = 0;
        last_sent    = 8'h00;
        spi_busy     = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(negedge clk);
            req = spi_ready_send && rst_n;
            if (req) begin
                rs_pulses++;
                if (first_rs_cyc < 0) first_rs_cyc = int'(cyc);
                check("rs_single_cycle", 32'(prev_rs), 32'd0);
                check("rs_cs_low", 32'(cs_n), 32'd0);
                check("rs_master_idle", 32'(spi_busy), 32'd0);
                if (tx_model.size() == 0) fail("rs_without_tx_byte");
                else check("spi_data_in", 32'(spi_data_in), 32'(tx_model.pop_front()));
                last_sent = spi_data_in;
            end
            prev_rs = spi_ready_send;
            @(posedge clk);
            #1;
            if (flush) begin
                spi_busy = 1'b0;
                cnt      = 0;
            end else if (req) begin
                spi_busy = 1'b1;
                cnt      = BUSY_LEN;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    spi_busy      = 1'b0;
                    spi_data_out  = loopback ? last_sent : 8'($urandom);
                    rx_exp.push_back(spi_data_out);
                    last_push_cyc = int'(cyc);
                end
            end
        end
    end

    // Burst-end monitor: done is one cycle and coincides with cs_n rising
    initial begin : end_mon
        bit prev_cs;
        bit prev_done;
        prev_cs   = 1'b1;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs   = 1'b1;
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_cyc = int'(cyc);
                    check("done_single_cycle", 32'(prev_done), 32'd0);
                    check("done_cs_rise", 32'({prev_cs, cs_n}), 32'd1);
                    check("done_active_low", 32'(active), 32'd0);
                end else if (!prev_cs && cs_n) begin
                    fail("cs_rise_with_done");
                end
                if (prev_cs && !cs_n) cs_fall_cyc = int'(cyc);
                prev_cs   = cs_n;
                prev_done = done;
            end
        end
    end

    task automatic start_burst(input logic [7:0] l, output int s);
        s     = int'(cyc);
        len   = l;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, input string name);
        int k = 0;
        while (done_cnt == base && k < limit) begin
            step(1);
            k++;
        end
        if (done_cnt == base) fail(name);
    endtask

    task automatic wait_pulses(input int target, input int limit, input string name);
        int k = 0;
        while (rs_pulses < target && k < limit) begin
            step(1);
            k++;
        end
        if (rs_pulses < target) fail(name);
    endtask

    task automatic wait_tx_drained(input int limit);
        int k = 0;
        while ((host_q.size() != 0 || tx_valid) && k < limit) begin
            step(1);
            k++;
        end
        if (host_q.size() != 0) fail("tx_preload_timeout");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no $finish, expected end of run (cyc %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int s, p0, d0, r0, k;
        rst_n = 1'b0;
        start = 1'b0;
        len   = 8'h00;
        abort = 1'b0;
        step(1);

        // Reset state
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_ready_send", 32'(spi_ready_send), 32'd0);
        check("rst_data_in", 32'(spi_data_in), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Basic 3-byte burst, loopback master, exact latencies
        loopback = 1'b1;
        host_q.push_back(8'hA5);
        host_q.push_back(8'h3C);
        host_q.push_back(8'hFF);
        wait_tx_drained(50);
        p0 = rs_pulses; d0 = done_cnt; r0 = rx_pops; first_rs_cyc = -1;
        start_burst(8'd3, s);
        check("basic_cs_fall", 32'(cs_fall_cyc), 32'(s + 1));
        wait_done(d0, 500, "basic_done_timeout");
        check("basic_pulses", 32'(rs_pulses - p0), 32'd3);
        check("basic_first_rs", 32'(first_rs_cyc), 32'(s + 1 + int'(SETUP)));
        check("basic_done_time", 32'(done_cyc), 32'(last_push_cyc + 1 + int'(HOLD)));
        step(20);
        check("basic_done_count", 32'(done_cnt - d0), 32'd1);
        check("basic_rx_count", 32'(rx_pops - r0), 32'd3);
        loopback = 1'b0;

        // len = 0 means 256 bytes
        p0 = rs_pulses; d0 = done_cnt; r0 = rx_pops;
        for (int i = 0; i < 256; i++) host_q.push_back(8'(i));
        start_burst(8'd0, s);
        wait_done(d0, 9000, "len0_done_timeout");
        check("len0_pulses", 32'(rs_pulses - p0), 32'd256);
        step(20);
        check("len0_rx_count", 32'(rx_pops - r0), 32'd256);
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);

        // TX underflow: second byte arrives late
        p0 = rs_pulses; d0 = done_cnt;
        host_q.push_back(8'($urandom));
        wait_tx_drained(50);
        start_burst(8'd2, s);
        wait_pulses(p0 + 1, 100, "uflow_first_timeout");
        step(BUSY_LEN + 50);
        check("uflow_stall_pulses", 32'(rs_pulses - p0), 32'd1);
        check("uflow_stall_cs", 32'(cs_n), 32'd0);
        check("uflow_stall_active", 32'(active), 32'd1);
        host_q.push_back(8'($urandom));
        wait_done(d0, 200, "uflow_done_timeout");
        check("uflow_pulses", 32'(rs_pulses - p0), 32'd2);

        // RX full: issue stalls at depth, one pop releases one transfer
        step(20);
        rx_en = 1'b0; rx_credit = 0;
        step(2);
        p0 = rs_pulses; d0 = done_cnt; r0 = rx_pops;
        for (int i = 0; i < 6; i++) host_q.push_back(8'($urandom));
        start_burst(8'd6, s);
        step(250);
        check("rxfull_pulses", 32'(rs_pulses - p0), 32'(DEPTH));
        check("rxfull_rx_valid", 32'(rx_valid), 32'd1);
        check("rxfull_cs", 32'(cs_n), 32'd0);
        rx_credit = 1;
        step(100);
        check("rxfull_release_pulses", 32'(rs_pulses - p0), 32'(DEPTH + 1));
        check("rxfull_release_pops", 32'(rx_pops - r0), 32'd1);
        rx_en = 1'b1;
        wait_done(d0, 300, "rxfull_done_timeout");
        check("rxfull_pulses_total", 32'(rs_pulses - p0), 32'd6);
        step(20);

        // Abort during byte 2 of 5
        p0 = rs_pulses; d0 = done_cnt; r0 = rx_pops;
        for (int i = 0; i < 5; i++) host_q.push_back(8'($urandom));
        start_burst(8'd5, s);
        wait_pulses(p0 + 2, 200, "abort_byte2_timeout");
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done(d0, 200, "abort_done_timeout");
        check("abort_pulses", 32'(rs_pulses - p0), 32'd2);
        check("abort_done_time", 32'(done_cyc), 32'(last_push_cyc + 1 + int'(HOLD)));
        step(20);
        check("abort_rx_count", 32'(rx_pops - r0), 32'd2);

        // Remaining 3 TX bytes are still queued for the next burst
        p0 = rs_pulses; d0 = done_cnt;
        start_burst(8'd3, s);
        wait_done(d0, 300, "abort_rest_timeout");
        check("abort_rest_pulses", 32'(rs_pulses - p0), 32'd3);
        step(20);

        // Abort during SETUP: no byte issued
        p0 = rs_pulses; d0 = done_cnt;
        start_burst(8'd1, s);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done(d0, 50, "abort_setup_timeout");
        check("abort_setup_pulses", 32'(rs_pulses - p0), 32'd0);
        check("abort_setup_done_time", 32'(done_cyc), 32'(s + 2 + int'(HOLD)));
        step(5);

        // Reset in the middle of XFER
        host_q.push_back(8'($urandom));
        host_q.push_back(8'($urandom));
        start_burst(8'd2, s);
        k = 0;
        while (!spi_busy && k < 100) begin step(1); k++; end
        if (!spi_busy) fail("reset_busy_timeout");
        step(4);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check("mid_rst_ready_send", 32'(spi_ready_send), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        flush = 1'b1;
        rx_exp.delete();
        tx_model.delete();
        step(3);
        #1;
        rst_n = 1'b1;
        flush = 1'b0;
        step(2);
        check("post_rst_cs_n", 32'(cs_n), 32'd1);

        // New burst after reset runs normally
        p0 = rs_pulses; d0 = done_cnt; r0 = rx_pops;
        host_q.push_back(8'($urandom));
        host_q.push_back(8'($urandom));
        wait_tx_drained(50);
        start_burst(8'd2, s);
        wait_done(d0, 300, "post_rst_done_timeout");
        check("post_rst_pulses", 32'(rs_pulses - p0), 32'd2);
        step(20);
        check("post_rst_rx_count", 32'(rx_pops - r0), 32'd2);

        check("final_rx_left", 32'(rx_exp.size()), 32'd0);
        check("final_tx_left", 32'(tx_model.size()), 32'd0);
        check("final_idle", 32'(active), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
